// File: rtl/pc_gen_if.sv
// pc_gen_if: control inputs and PC status outputs of the program-counter generator
interface pc_gen_if #(parameter int XLEN = 32);
  logic            wr_im;
  logic            start;
  logic            stall;
  logic            branch;
  logic [XLEN-1:0] branch_target;
  logic            trap;
  logic            mret;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] epc;
  logic            pc_valid;
  logic            misalign;
  logic [1:0]      state_o;
  modport master (
    output wr_im, start, stall, branch, branch_target, trap, mret, halt_req, resume,
    input  pc, epc, pc_valid, misalign, state_o
  );
  modport slave (
    input  wr_im, start, stall, branch, branch_target, trap, mret, halt_req, resume,
    output pc, epc, pc_valid, misalign, state_o
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program counter for load/run/halt phases with trap redirect, EPC capture and trap return
module pc_gen #(
  parameter int              XLEN        = 32,
  parameter int              INST_BYTES  = 4,
  parameter logic [XLEN-1:0] LOAD_BASE   = '0,
  parameter logic [XLEN-1:0] BOOT_ADDR   = '0,
  parameter logic [XLEN-1:0] TRAP_VEC    = 'h100,
  parameter int              ALIGN_CHECK = 1
) (
  input logic       clk,
  input logic       rst,
  pc_gen_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;
  localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] MASK = XLEN'(INST_BYTES - 1);
  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] epc;
  logic            mis_q;
  logic            bad_tgt;
  assign bad_tgt = (ALIGN_CHECK != 0) && bus.branch && !bus.stall && ((bus.branch_target & MASK) != '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= LOAD_BASE;
      epc   <= '0;
      mis_q <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      case (state)
        IDLE: if (bus.wr_im) begin
          state <= LOAD;
          pc    <= pc + STEP;
        end
        LOAD: if (bus.start) begin
          state <= RUN;
          pc    <= BOOT_ADDR;
        end else if (bus.wr_im) pc <= pc + STEP;
        RUN: if (bus.trap || bad_tgt) begin
          epc   <= pc;
          pc    <= TRAP_VEC;
          mis_q <= !bus.trap;
        end else if (bus.mret) pc <= epc;
        else if (bus.halt_req) state <= HALT;
        else if (bus.stall) pc <= pc;
        else if (bus.branch) pc <= bus.branch_target;
        else pc <= pc + STEP;
        HALT: if (bus.resume) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.pc       = pc;
  assign bus.epc      = epc;
  assign bus.misalign = mis_q;
  assign bus.state_o  = state;
  assign bus.pc_valid = (state == RUN) && !bus.stall;
endmodule
